// File: rtl/sensor_alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sensor_alarm_pkg
//  Brief   : Shared state encoding and width helper for sensor_alarm_voter.
//  Rev     : 1.0 - initial release
// ============================================================================
package sensor_alarm_pkg;

  // Voter FSM encoding; 2'd3 is unused and recovers to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_ALARM = 2'd2
  } state_t;

  // Bits needed to hold any value 0..n.
  function automatic int CNT_W(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pop_count.sv
`default_nettype none
// ============================================================================
//  Module  : pop_count
//  Brief   : Purely combinational population count of an N-bit vector.
//  Rev     : 1.0 - initial release
// ============================================================================
module pop_count #(
  parameter int N = 4
) (
  input  logic [N-1:0]            vec_i,
  output logic [$clog2(N+1)-1:0]  cnt_o
);

  localparam int W = $clog2(N + 1);

  // Sum the individual bits of the vector.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) begin
      cnt_o = cnt_o + W'(vec_i[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sensor_alarm_voter.sv
`default_nettype none
// ============================================================================
//  Module  : sensor_alarm_voter
//  Brief   : Registers an N-bit sensor vector, counts active inputs and raises
//            alarm after HOLD_CYC consecutive samples with at least THRESH
//            active inputs.
//            Build option: define ALARM_LATCH_EN to hold the alarm until it is
//            acknowledged (ack=1) on a cycle where the condition has cleared.
//  Rev     : 1.0 - initial release
// ============================================================================
module sensor_alarm_voter
  import sensor_alarm_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int THRESH   = N_IN,
  parameter int HOLD_CYC = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_IN-1:0]           in_vec,
  input  logic                      ack,
  output logic                      alarm,
  output logic [$clog2(N_IN+1)-1:0] active_cnt,
  output logic [1:0]                state_o
);

  localparam int CW = CNT_W(N_IN);
  localparam int HW = CNT_W(HOLD_CYC);
  localparam logic [CW-1:0] THRESH_C   = CW'(THRESH);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] HOLD_FIRST = HW'(1);

  // Reject parameter sets that can never or always qualify.
  if (THRESH < 1 || THRESH > N_IN || HOLD_CYC < 1) begin : g_param_check
    $error("sensor_alarm_voter: need 1 <= THRESH <= N_IN and HOLD_CYC >= 1");
  end

  logic [N_IN-1:0] in_q;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  state_t          state_q, state_d;
  logic [CW-1:0]   w_cnt;
  logic            w_hit;

  pop_count #(.N(N_IN)) u_pop_count (
    .vec_i (in_q),
    .cnt_o (w_cnt)
  );

  assign w_hit = (w_cnt >= THRESH_C);

`ifndef ALARM_LATCH_EN
  // Acknowledge is meaningless when the alarm follows the condition directly.
  logic unused_ack;
  assign unused_ack = ack;
`endif

  // State, qualification counter and input sample registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      in_q       <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      in_q       <= in_vec;
    end
  end

  // Next-state logic: count consecutive qualifying samples, then alarm.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        hold_cnt_d = '0;
        if (w_hit) begin
          if (HOLD_CYC == 1) begin
            state_d = ST_ALARM;
          end else begin
            state_d    = ST_PEND;
            hold_cnt_d = HOLD_FIRST;
          end
        end
      end
      ST_PEND: begin
        // Any non-qualifying sample restarts qualification from zero.
        if (!w_hit) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_ALARM;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_ALARM: begin
`ifdef ALARM_LATCH_EN
        // Acknowledge only counts once the condition is already gone.
        if (ack && !w_hit) begin
`else
        if (!w_hit) begin
`endif
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Outputs decoded straight from the registered state and input sample.
  always_comb begin
    alarm      = (state_q == ST_ALARM);
    state_o    = state_q;
    active_cnt = w_cnt;
  end

endmodule
`default_nettype wire

// File: doc/sensor_alarm_voter.md
# sensor_alarm_voter

Parametrised, clocked successor to the four-input gate-level alarm circuit: samples an N-bit vector of sensor inputs, counts how many are active, and raises `alarm` only when at least THRESH inputs have been active for HOLD_CYC consecutive cycles. It debounces the input vector and can optionally latch the alarm until it is acknowledged. It sits between raw sensor inputs and the system indicator/interrupt logic.

## Interface
- `N_IN`, 4: number of sensor inputs; 1 or more.
- `THRESH`, `N_IN`: minimum active-input count that qualifies; range 1..`N_IN`. The default makes the block an all-inputs-high detector.
- `HOLD_CYC`, 3: number of consecutive qualifying cycles required before alarm; 1 or more.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_vec` in `N_IN`: sensor inputs, sampled every edge.
- `ack` in 1: alarm acknowledge; used only when `ALARM_LATCH_EN` is defined.
- `alarm` out 1: alarm indication; registered.
- `active_cnt` out `$clog2(N_IN+1)`: popcount of the registered input sample.
- `state_o` out 2: current FSM state, for debug.

## Operation
- Input register `in_q` captures `in_vec` on every edge.
- `hit` = (popcount(`in_q`) >= `THRESH`), computed combinationally. `active_cnt` = popcount(`in_q`).
- FSM states: IDLE=0, PEND=1, ALARM=2. Encoding 3 is unused and must recover to IDLE on the next edge.
- IDLE: if `hit` and `HOLD_CYC`==1, go to ALARM. If `hit` and `HOLD_CYC`>1, go to PEND with `hold_cnt`=1. Otherwise stay in IDLE.
- PEND:
  - If `hit` is false, go to IDLE and clear `hold_cnt`.
  - Else, if `hold_cnt`==`HOLD_CYC`-1, go to ALARM.
  - Else, increment `hold_cnt`.
- ALARM: exit conditions are given under Configuration. On entering IDLE, `hold_cnt` is cleared.
- `alarm` = (state==ALARM), decoded directly from the state register with no extra delay.
- `hold_cnt` width is `$clog2(HOLD_CYC+1)` and it never wraps. It saturates at `HOLD_CYC`-1 because PEND always exits at that value.
- Reset values: state=IDLE, `hold_cnt`=0, `in_q`=0, `alarm`=0, `active_cnt`=0, `state_o`=0.
- Reset asserted mid-PEND or mid-ALARM: the reset values above apply after the edge. Reset has priority over `hit` and `ack`.
- Elaboration must fail if `THRESH` is 0, `THRESH` > `N_IN`, or `HOLD_CYC` is 0.

## Timing
- `in_vec` is qualifying from the edge-1 sample onward → `alarm` rises after edge `HOLD_CYC`+1.
- Latency is `HOLD_CYC`+1 cycles and requires `HOLD_CYC` consecutive qualifying samples.
- A single non-qualifying sample during PEND restarts qualification from zero.
- `active_cnt` lags `in_vec` by exactly one cycle.
- Non-latched clear: `in_vec` stops qualifying at sample k → `alarm` falls after edge k+1.
- `ack` has no effect in IDLE or PEND.

## Configuration
- `ALARM_LATCH_EN` defined:
  - ALARM goes to IDLE only on an edge where `ack`=1 and `hit`=0.
  - `ack` while `hit`=1 is ignored: no memory, no pending clear.
  - `ack` must be reasserted once the condition is gone.
- `ALARM_LATCH_EN` undefined:
  - ALARM goes to IDLE on the first edge with `hit`=0.
  - `ack` is ignored everywhere. The port stays in the interface so instantiation is identical in both builds.

## Structure
- Shared package `sensor_alarm_pkg` holds:
  - the state typedef and encodings (IDLE/PEND/ALARM), used by RTL and bench;
  - a `CNT_W(n)` width helper function.
- One sub-module: `pop_count`, parametrised on `N`, purely combinational, output width `$clog2(N+1)`. It is reused for `active_cnt` and `hit`.

## Test plan
All scenarios use `N_IN`=4, `THRESH`=4, `HOLD_CYC`=3 unless stated.
- Reset, then walk `in_vec` through 0000, 0001, 0011, 0111, 1111 for 20 cycles each → `active_cnt` reads 0,1,2,3,4 one cycle late; `alarm` rises 4 cycles after 1111 is first sampled.
- Glitch: 1111 for 2 cycles, 1110 for 1 cycle, then 1111 → state returns to IDLE; `alarm` rises only 4 cycles after the final 1111.
- Non-latched build: alarm active, then `in_vec`=0111 → `alarm` falls 2 edges later.
- Latched build: alarm active, `in_vec`=0000 with `ack`=0 → `alarm` holds. Then `ack`=1 with `in_vec`=1111 → still held. Then `ack`=1 with `in_q`=0000 → `alarm` falls the next edge.
- `THRESH`=2, `HOLD_CYC`=1: `in_vec`=1001 → `alarm` rises after edge 2. `in_vec`=1000 → PEND is never entered.
- `rst` pulsed for 1 cycle in PEND and again in ALARM with `in_vec`=1111 held → all outputs are 0 the next cycle, and qualification restarts, giving `alarm` after 4 cycles.
